// File: rtl/sr_flop_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : sr_flop_bank_if
// Purpose  : Bundles the per-channel command inputs and the status outputs
//            of sr_flop_bank so they can be passed around as one port.
// Signals  : S_n, R_n  [WIDTH] active-low set / reset commands
//            ERR_CLR         synchronous clear of the sticky error flags
//            Q, Q_not [WIDTH] stored state and its complement
//            ERR      [WIDTH] sticky invalid-command flags
//            ERR_ANY         OR of all ERR bits
//            INV_CNT  [8]    saturating invalid-event count
//                            (present only with SR_INV_COUNT_EN)
// Modports : master drives commands; slave is the flop bank itself.
// Revision : 1.0 - initial release
// ============================================================================
interface sr_flop_bank_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] S_n;
  logic [WIDTH-1:0] R_n;
  logic             ERR_CLR;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] Q_not;
  logic [WIDTH-1:0] ERR;
  logic             ERR_ANY;
`ifdef SR_INV_COUNT_EN
  logic [7:0]       INV_CNT;

  modport master (output S_n, R_n, ERR_CLR,
                  input  Q, Q_not, ERR, ERR_ANY, INV_CNT);
  modport slave  (input  S_n, R_n, ERR_CLR,
                  output Q, Q_not, ERR, ERR_ANY, INV_CNT);
`else
  modport master (output S_n, R_n, ERR_CLR,
                  input  Q, Q_not, ERR, ERR_ANY);
  modport slave  (input  S_n, R_n, ERR_CLR,
                  output Q, Q_not, ERR, ERR_ANY);
`endif
endinterface
`default_nettype wire

// File: rtl/sr_flop_bank.sv
`default_nettype none
// ============================================================================
// Module   : sr_flop_bank
// Purpose  : WIDTH independent clocked SR storage channels with active-low
//            set/reset commands, a per-channel stability (glitch) filter,
//            configurable resolution of the invalid both-low command and
//            sticky per-channel invalid-command error flags.
// Ports    : CLK    rising-edge clock
//            RST_N  asynchronous active-low reset
//            bus    sr_flop_bank_if.slave (S_n, R_n, ERR_CLR in;
//                   Q, Q_not, ERR, ERR_ANY [, INV_CNT] out)
// Params   : WIDTH    number of channels
//            FILT     sampled cycles a command must be stable (1..15,
//                     0 behaves as 1)
//            INV_MODE invalid command action: 0 hold, 1 set, 2 clear
//                     (3 and above behave as 0)
//            RST_VAL  reset value of every Q bit
// Options  : SR_INV_COUNT_EN adds an 8-bit saturating count of qualified
//            invalid events on bus.INV_CNT.
// Revision : 1.0 - initial release
// ============================================================================
module sr_flop_bank #(
  parameter int WIDTH    = 8,
  parameter int FILT     = 2,
  parameter int INV_MODE = 0,
  parameter int RST_VAL  = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  sr_flop_bank_if.slave bus
);

  // Out-of-range parameters are folded onto legal values here so the rest
  // of the logic only ever sees a valid filter length and action.
  localparam logic [3:0] c_FILT_EFF     = (FILT <= 0)  ? 4'd1  :
                                          (FILT >= 15) ? 4'd15 : 4'(FILT);
  localparam int         c_INV_MODE_EFF = (INV_MODE == 1 || INV_MODE == 2) ?
                                          INV_MODE : 0;
  localparam logic       c_RST_BIT      = (RST_VAL != 0);

  logic [WIDTH-1:0] r_s_q;
  logic [WIDTH-1:0] r_r_q;
  logic [3:0]       r_cnt [WIDTH];
  logic [WIDTH-1:0] r_fresh;    // sample qualifies for the first time
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_err;

  logic [WIDTH-1:0] w_same;
  logic [3:0]       w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_fresh_nxt;
  logic [WIDTH-1:0] w_inv_new;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_err_nxt;

  always_comb begin
    w_same      = '0;
    w_fresh_nxt = '0;
    w_inv_new   = '0;
    w_q_nxt     = r_q;
    w_err_nxt   = r_err;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = 4'd1;

      w_same[i] = (bus.S_n[i] == r_s_q[i]) && (bus.R_n[i] == r_r_q[i]);
      if (w_same[i]) begin
        w_cnt_nxt[i] = (r_cnt[i] >= c_FILT_EFF) ? c_FILT_EFF : r_cnt[i] + 4'd1;
      end

      // A qualification is "new" when the counter reaches FILT from below,
      // or when a changed sample qualifies immediately (FILT of 1). A sample
      // that simply stays qualified is a repeat, not a new event.
      w_fresh_nxt[i] = (w_cnt_nxt[i] == c_FILT_EFF) &&
                       !(w_same[i] && (r_cnt[i] == c_FILT_EFF));

      w_inv_new[i] = r_fresh[i] & ~r_s_q[i] & ~r_r_q[i];

      // The registered sample is the command; it is applied on every cycle
      // it stays qualified, which is harmless since all actions are
      // idempotent.
      if (r_cnt[i] == c_FILT_EFF) begin
        case ({r_s_q[i], r_r_q[i]})
          2'b01:   w_q_nxt[i] = 1'b1;
          2'b10:   w_q_nxt[i] = 1'b0;
          2'b00: begin
            if (c_INV_MODE_EFF == 1)      w_q_nxt[i] = 1'b1;
            else if (c_INV_MODE_EFF == 2) w_q_nxt[i] = 1'b0;
          end
          default: w_q_nxt[i] = r_q[i];
        endcase
      end

      // A new invalid qualification wins over a simultaneous clear.
      w_err_nxt[i] = w_inv_new[i] | (r_err[i] & ~bus.ERR_CLR);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_s_q   <= '1;
      r_r_q   <= '1;
      r_fresh <= '0;
      r_q     <= {WIDTH{c_RST_BIT}};
      r_err   <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= 4'd0;
      end
    end else begin
      r_s_q   <= bus.S_n;
      r_r_q   <= bus.R_n;
      r_fresh <= w_fresh_nxt;
      r_q     <= w_q_nxt;
      r_err   <= w_err_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
    end
  end

  assign bus.Q       = r_q;
  assign bus.Q_not   = ~r_q;
  assign bus.ERR     = r_err;
  assign bus.ERR_ANY = |r_err;

`ifdef SR_INV_COUNT_EN
  logic [7:0]  r_inv_cnt;
  logic [31:0] w_inc;
  logic [31:0] w_sum;
  logic [7:0]  w_inv_cnt_nxt;

  // A clear in the same cycle as new events restarts the count from the
  // increment rather than from zero.
  always_comb begin
    w_inc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_inc = w_inc + 32'(w_inv_new[i]);
    end
    w_sum         = (bus.ERR_CLR ? 32'd0 : 32'(r_inv_cnt)) + w_inc;
    w_inv_cnt_nxt = (w_sum > 32'd255) ? 8'hFF : w_sum[7:0];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_inv_cnt <= 8'd0;
    end else begin
      r_inv_cnt <= w_inv_cnt_nxt;
    end
  end

  assign bus.INV_CNT = r_inv_cnt;
`else
  // Invalid-event counter not built.
`endif

endmodule
`default_nettype wire

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Parametrised, clocked successor to the behavioural NAND SR latch.
- WIDTH independent SR storage channels with active-low (NAND-style) set/reset inputs and a per-channel glitch filter.
- Configurable resolution of the invalid (both-low) command, plus sticky per-channel invalid-error flags.
- Used wherever asynchronous-origin set/clear requests (status bits, interrupt pending flags) must be stored in the CLK domain.

Parameters:
- WIDTH, 8: number of channels.
- FILT, 2: consecutive sampled cycles a command must be stable before it takes effect (1 to 15).
- INV_MODE, 0: action on invalid command (0 = hold, 1 = force Q=1, 2 = force Q=0).
- RST_VAL, 0: reset value of every Q bit.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- S_n  in  WIDTH  active-low set per channel.
- R_n  in  WIDTH  active-low reset per channel.
- ERR_CLR  in  1  synchronous clear of all ERR bits.
- Q  out  WIDTH  stored state.
- Q_not  out  WIDTH  always the exact complement of Q.
- ERR  out  WIDTH  sticky invalid-command flag per channel.
- ERR_ANY  out  1  OR-reduction of ERR (combinational from registered ERR).

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (RST_N low) takes effect immediately, with no clock edge required:
  - Q = {WIDTH{RST_VAL}}, Q_not = ~Q, ERR = 0.
  - Sample registers s_q/r_q = 1 (idle), stability counters = 0.
  - Any pending command is discarded.
- Per channel, each rising edge:
  - Sample: {s_q, r_q} <= {S_n[i], R_n[i]}.
  - Stability counter cnt (4 bits):
    - if the new sample equals the previous sample, cnt <= min(cnt+1, FILT);
    - otherwise cnt <= 1.
  - A command is qualified on the cycle cnt == FILT. It is re-applied every cycle while stable; all commands are idempotent.
- Latency:
  - Input change set up before edge k is sampled at edge k.
  - Q changes at edge k+FILT.
  - Pulses shorter than FILT sampled cycles have no effect.
- Qualified command decode (active low):
  - (0,1): Q=1 (set).
  - (1,0): Q=0 (reset).
  - (1,1): hold.
  - (0,0): invalid. INV_MODE 0 holds, INV_MODE 1 sets, INV_MODE 2 resets.
  - Q_not is never equal to Q. No Z or X outputs in any state.
- ERR[i]:
  - Set on the first cycle a (0,0) command qualifies (cnt transitions to FILT).
  - Stays set until ERR_CLR or reset.
  - ERR_CLR clears all ERR bits at the next edge.
  - If ERR_CLR and a new qualification occur in the same cycle, the set wins for that channel.
- Channels are fully independent. Simultaneous commands on different channels are all applied in the same cycle.
- Reset deassertion: with inputs at (1,1), state holds RST_VAL. With an active input, the command qualifies FILT edges after the first sampling edge.
- Illegal parameters:
  - INV_MODE values 3 and above behave as 0.
  - FILT = 0 is treated as 1.

Optional Feature:
- Macro: SR_INV_COUNT_EN.
- When defined:
  - Extra output INV_CNT [7:0]: a saturating count of qualified invalid events.
  - Each edge adds the number of channels whose (0,0) command qualifies that cycle; the count saturates at 255.
  - Cleared by reset and by ERR_CLR. A same-cycle clear and increment loads the increment.
- When undefined: the port and counter logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Reset: WIDTH=4, FILT=2, INV_MODE=0, RST_VAL=0. Assert RST_N low mid-cycle with random inputs -> Q=4'h0, Q_not=4'hF, ERR=0 immediately. Release with S_n=R_n=4'hF -> Q stays 4'h0.
- Set latency: S_n=4'hE applied before edge k -> Q=4'h1 exactly at edge k+2, still 4'h0 after edge k+1. Return S_n to 4'hF -> Q holds 4'h1.
- Glitch filter: from Q[0]=1, R_n=4'hE for one sampled cycle -> Q stays 4'h1. R_n=4'hE for two cycles -> Q=4'h0, Q_not=4'hF.
- Invalid: S_n=R_n=4'hD held 3 cycles with INV_MODE=0 -> Q[1] unchanged, ERR=4'h2, ERR_ANY=1. Pulse ERR_CLR with inputs at 4'hF -> ERR=4'h0. Rerun with INV_MODE=2 from Q[1]=1 -> Q[1]=0, ERR=4'h2.
- Reset mid-qualification: S_n=4'h7 sampled once (cnt=1), then RST_N low between edges -> Q=4'h0 without a clock edge. After release with S_n=4'hF, Q[3] never sets.
- SR_INV_COUNT_EN: channels 0, 1 and 2 go invalid together -> INV_CNT increments by 3 in one cycle. Repeat until the count reaches 255 -> INV_CNT stays 255. ERR_CLR -> INV_CNT=0.
